// File: rtl/wb_fwd_pkg.sv
// -----------------------------------------------------------------------------
// wb_fwd_pkg
// Shared definitions for the forwarding-source slice: default widths and the
// M-slot state encoding used by wb_forward_source.
// -----------------------------------------------------------------------------
package wb_fwd_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

    // M slot: empty, holding a load that still waits for memory data,
    // or holding a complete result ready to move into W.
    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_LWAIT = 2'd1,
        M_HOLD  = 2'd2
    } m_state_e;

endpackage : wb_fwd_pkg

// File: rtl/wb_forward_source_if.sv
// -----------------------------------------------------------------------------
// wb_forward_source_if
// Bundles the execute hand-off, the load-data return and the register-file
// write port of wb_forward_source.
//   ex_valid/ex_ready/ex_rd/ex_result/ex_is_load : execute -> M handshake
//   mem_rvalid/mem_rdata                         : load data return
//   rf_ready/rf_we/rf_waddr/rf_wdata             : register-file write port
// Modports:
//   master : execute / memory / register-file side (drives requests)
//   slave  : wb_forward_source side
// -----------------------------------------------------------------------------
interface wb_forward_source_if
    import wb_fwd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  ex_valid;
    logic                  ex_ready;
    logic [ADDR_WIDTH-1:0] ex_rd;
    logic [DATA_WIDTH-1:0] ex_result;
    logic                  ex_is_load;

    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  rf_ready;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    modport master (
        output ex_valid, ex_rd, ex_result, ex_is_load,
        output mem_rvalid, mem_rdata,
        output rf_ready,
        input  ex_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  ex_valid, ex_rd, ex_result, ex_is_load,
        input  mem_rvalid, mem_rdata,
        input  rf_ready,
        output ex_ready, rf_we, rf_waddr, rf_wdata
    );

endinterface : wb_forward_source_if

// File: rtl/wb_slot.sv
// -----------------------------------------------------------------------------
// wb_slot
// One pipeline slot: valid flag plus destination address and data.
// Ports:
//   clk, rst    : clock, async active-high reset (clears all fields)
//   ld          : load valid/addr/data (takes priority over clr)
//   ld_data     : update data only (late load data)
//   clr         : drop the entry
//   addr_in/data_in : values to capture
//   valid       : slot occupied
//   live        : slot occupied and visible to forwarding / rf write
//   addr/data   : held contents
// SUPPRESS_X0 hides entries targeting register 0 from 'live'.
// -----------------------------------------------------------------------------
module wb_slot #(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter bit          SUPPRESS_X0 = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld,
    input  logic                  ld_data,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid,
    output logic                  live,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (ld) begin
            // A refill on the same edge as the outgoing move keeps the slot full.
            valid <= 1'b1;
            addr  <= addr_in;
            data  <= data_in;
        end else begin
            if (ld_data) begin
                data <= data_in;
            end
            if (clr) begin
                valid <= 1'b0;
            end
        end
    end

    assign live = valid & (!SUPPRESS_X0 | (addr != '0));

endmodule : wb_slot

// File: rtl/wb_forward_source.sv
// -----------------------------------------------------------------------------
// wb_forward_source
// Producer side of operand forwarding. Carries executed results through the
// M and W slots, drives the register-file write port and advertises each
// slot's {valid, addr, data} for bypassing. Loads wait in M until their data
// returns; m_fwd_pending tells consumers to stall on such a register.
// Ports:
//   clk, rst        : clock, async active-high reset
//   bus (slave)     : execute handshake, load data return, rf write port
//   m_fwd_valid/pending/addr/data : M slot forwarding view
//   w_fwd_valid/addr/data         : W slot forwarding view (valid == rf_we)
//   retire_cnt      : completed rf writes, wraps
//   err_unexp_rdata : sticky, load data arrived with no load waiting
// Build option: define X0_SUPPRESS_EN to hide register-0 results from
// forwarding and rf writes (they still flow through and count as retired).
// -----------------------------------------------------------------------------
module wb_forward_source
    import wb_fwd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_forward_source_if.slave    bus,
    output logic                  m_fwd_valid,
    output logic                  m_fwd_pending,
    output logic [ADDR_WIDTH-1:0] m_fwd_addr,
    output logic [DATA_WIDTH-1:0] m_fwd_data,
    output logic                  w_fwd_valid,
    output logic [ADDR_WIDTH-1:0] w_fwd_addr,
    output logic [DATA_WIDTH-1:0] w_fwd_data,
    output logic [CNT_WIDTH-1:0]  retire_cnt,
    output logic                  err_unexp_rdata
);

`ifdef X0_SUPPRESS_EN
    localparam bit SUPPRESS_X0 = 1'b1;
`else
    localparam bit SUPPRESS_X0 = 1'b0;
`endif

    m_state_e m_state, m_next;

    logic                  m_valid, m_live;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  w_valid, w_live;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;

    logic                  w_adv;
    logic                  m_move;
    logic                  accept;
    logic                  ld_capture;
    logic                  retire;
    logic [DATA_WIDTH-1:0] m_data_in;

    // Handshake glue: W frees up on the same edge it retires, so M can move
    // and a new op can enter M all on one edge.
    assign w_adv         = !w_valid | bus.rf_ready;
    assign m_move        = (m_state == M_HOLD) & w_adv;
    // The M slot's valid flag tracks M != IDLE exactly.
    assign bus.ex_ready  = !m_valid | m_move;
    assign accept        = bus.ex_valid & bus.ex_ready;
    assign ld_capture    = (m_state == M_LWAIT) & bus.mem_rvalid;
    assign retire        = w_valid & bus.rf_ready;
    assign m_data_in     = ld_capture ? bus.mem_rdata : bus.ex_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= M_IDLE;
        end else begin
            m_state <= m_next;
        end
    end

    always_comb begin
        m_next = m_state;
        unique case (m_state)
            M_IDLE: begin
                if (accept) begin
                    m_next = bus.ex_is_load ? M_LWAIT : M_HOLD;
                end
            end
            M_LWAIT: begin
                if (bus.mem_rvalid) begin
                    m_next = M_HOLD;
                end
            end
            M_HOLD: begin
                if (accept) begin
                    m_next = bus.ex_is_load ? M_LWAIT : M_HOLD;
                end else if (m_move) begin
                    m_next = M_IDLE;
                end
            end
            default: m_next = M_IDLE;
        endcase
    end

    wb_slot #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .SUPPRESS_X0 (SUPPRESS_X0)
    ) u_m_slot (
        .clk     (clk),
        .rst     (rst),
        .ld      (accept),
        .ld_data (ld_capture),
        .clr     (m_move),
        .addr_in (bus.ex_rd),
        .data_in (m_data_in),
        .valid   (m_valid),
        .live    (m_live),
        .addr    (m_addr),
        .data    (m_data)
    );

    wb_slot #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .SUPPRESS_X0 (SUPPRESS_X0)
    ) u_w_slot (
        .clk     (clk),
        .rst     (rst),
        .ld      (m_move),
        .ld_data (1'b0),
        .clr     (retire),
        .addr_in (m_addr),
        .data_in (m_data),
        .valid   (w_valid),
        .live    (w_live),
        .addr    (w_addr),
        .data    (w_data)
    );

    // Retire counter and sticky unexpected-data flag. Data arriving on the
    // same edge a load is accepted from IDLE is unexpected: M is not LWAIT yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt      <= '0;
            err_unexp_rdata <= 1'b0;
        end else begin
            if (retire) begin
                retire_cnt <= retire_cnt + CNT_WIDTH'(1);
            end
            if (bus.mem_rvalid && (m_state != M_LWAIT)) begin
                err_unexp_rdata <= 1'b1;
            end
        end
    end

    assign m_fwd_valid   = (m_state == M_HOLD)  & m_live;
    assign m_fwd_pending = (m_state == M_LWAIT) & m_live;
    assign m_fwd_addr    = m_addr;
    assign m_fwd_data    = m_data;

    assign w_fwd_valid   = w_live;
    assign w_fwd_addr    = w_addr;
    assign w_fwd_data    = w_data;

    assign bus.rf_we     = w_live;
    assign bus.rf_waddr  = w_addr;
    assign bus.rf_wdata  = w_data;

endmodule : wb_forward_source
